// File: rtl/mix_column.sv
// One output byte of AES MixColumns / InvMixColumns over GF(2^8), poly 0x11B.
// The byte is picked by row and registered with one cycle of latency.
module mix_column (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       inv,
   input  logic [1:0] row,
   input  logic [7:0] col_in0,
   input  logic [7:0] col_in1,
   input  logic [7:0] col_in2,
   input  logic [7:0] col_in3,
   output logic [7:0] col_out,
   output logic       out_valid
);

   function automatic logic [7:0] xtime(input logic [7:0] x);
      xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   logic [7:0] w_a   [4];
   logic [7:0] w_xt1 [4];
   logic [7:0] w_xt2 [4];
   logic [7:0] w_xt3 [4];
   logic [7:0] w_m2  [4];
   logic [7:0] w_m3  [4];
   logic [7:0] w_m9  [4];
   logic [7:0] w_mb  [4];
   logic [7:0] w_md  [4];
   logic [7:0] w_me  [4];
   logic [7:0] w_fwd;
   logic [7:0] w_inv;
   logic [7:0] w_res;

   assign w_a[0] = col_in0;
   assign w_a[1] = col_in1;
   assign w_a[2] = col_in2;
   assign w_a[3] = col_in3;

   // Every constant product of every byte is formed; the row mux then picks them.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_xt1[k] = xtime(w_a[k]);
         w_xt2[k] = xtime(w_xt1[k]);
         w_xt3[k] = xtime(w_xt2[k]);
         w_m2[k]  = w_xt1[k];
         w_m3[k]  = w_xt1[k] ^ w_a[k];
         w_m9[k]  = w_xt3[k] ^ w_a[k];
         w_mb[k]  = w_xt3[k] ^ w_xt1[k] ^ w_a[k];
         w_md[k]  = w_xt3[k] ^ w_xt2[k] ^ w_a[k];
         w_me[k]  = w_xt3[k] ^ w_xt2[k] ^ w_xt1[k];
      end
   end

   always_comb begin
      w_fwd = 8'h00;
      w_inv = 8'h00;
      case (row)
         2'd0: begin
            w_fwd = w_m2[0] ^ w_m3[1] ^ w_a[2]  ^ w_a[3];
            w_inv = w_me[0] ^ w_mb[1] ^ w_md[2] ^ w_m9[3];
         end
         2'd1: begin
            w_fwd = w_a[0]  ^ w_m2[1] ^ w_m3[2] ^ w_a[3];
            w_inv = w_m9[0] ^ w_me[1] ^ w_mb[2] ^ w_md[3];
         end
         2'd2: begin
            w_fwd = w_a[0]  ^ w_a[1]  ^ w_m2[2] ^ w_m3[3];
            w_inv = w_md[0] ^ w_m9[1] ^ w_me[2] ^ w_mb[3];
         end
         default: begin
            w_fwd = w_m3[0] ^ w_a[1]  ^ w_a[2]  ^ w_m2[3];
            w_inv = w_mb[0] ^ w_md[1] ^ w_m9[2] ^ w_me[3];
         end
      endcase
   end

   assign w_res = inv ? w_inv : w_fwd;

   logic [7:0] r_col_out;
   logic       r_out_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col_out   <= 8'h00;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) r_col_out <= w_res;
      end
   end

   assign col_out   = r_col_out;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mix_column.sv
// Self-checking bench for mix_column: vector table, hold/reset sequences,
// random vectors against a shift-and-add GF(2^8) model, and round trips.
module tb_mix_column;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       inv = 1'b0;
   logic [1:0] row = 2'd0;
   logic [7:0] col_in0 = 8'h00, col_in1 = 8'h00, col_in2 = 8'h00, col_in3 = 8'h00;
   logic [7:0] col_out;
   logic       out_valid;

   mix_column dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .inv(inv), .row(row),
      .col_in0(col_in0), .col_in1(col_in1), .col_in2(col_in2), .col_in3(col_in3),
      .col_out(col_out), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] sb_q[$];
   logic [7:0] hold_val = 8'h00;

   typedef struct {
      logic       inv;
      logic [1:0] row;
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] model(input logic iv, input logic [1:0] r,
                                        input logic [7:0] a0, a1, a2, a3);
      logic [7:0] m[4];
      logic [7:0] a[4];
      logic [7:0] b = 8'h00;
      a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
      if (iv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
      else    begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
      for (int k = 0; k < 4; k++) b ^= gf_mul(m[(k - int'(r)) & 3], a[k]);
      return b;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Drive one cycle of stimulus; expected byte e is pushed only for a real capture.
   task automatic step(input string name, input logic r_v, input logic v, input logic iv,
                       input logic [1:0] r, input logic [7:0] a0, a1, a2, a3,
                       input logic [7:0] e);
      logic [7:0] exp_out;
      logic       exp_v;
      rst = r_v; in_valid = v; inv = iv; row = r;
      col_in0 = a0; col_in1 = a1; col_in2 = a2; col_in3 = a3;
      if (!r_v && v) sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (r_v) begin
         exp_out = 8'h00; exp_v = 1'b0;
      end else if (v) begin
         exp_v = 1'b1;
         if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty got %02h expected entry", name, col_out);
            exp_out = col_out;
         end else exp_out = sb_q.pop_front();
      end else begin
         exp_out = hold_val; exp_v = 1'b0;
      end
      hold_val = exp_out;
      chk({name, "_valid"}, {7'd0, out_valid}, {7'd0, exp_v});
      chk({name, "_data"}, col_out, exp_out);
   endtask

   function automatic void addv(input logic iv, input logic [1:0] r,
                                input logic [7:0] a0, a1, a2, a3, e);
      vec_t v;
      v.inv = iv; v.row = r; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3; v.exp = e;
      vecs.push_back(v);
   endfunction

   initial begin
      logic [7:0] exp_f[4];
      logic [7:0] fw  [4];
      logic [7:0] c   [4];
      logic [7:0] e_l [4];

      e_l[0] = 8'h04; e_l[1] = 8'h66; e_l[2] = 8'h81; e_l[3] = 8'he5;
      for (int r = 0; r < 4; r++) addv(1'b0, 2'(r), 8'hd4, 8'hbf, 8'h5d, 8'h30, e_l[r]);
      e_l[0] = 8'h8e; e_l[1] = 8'h4d; e_l[2] = 8'ha1; e_l[3] = 8'hbc;
      for (int r = 0; r < 4; r++) addv(1'b0, 2'(r), 8'hdb, 8'h13, 8'h53, 8'h45, e_l[r]);
      for (int r = 0; r < 4; r++) addv(1'b0, 2'(r), 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
      for (int r = 0; r < 4; r++) addv(1'b0, 2'(r), 8'hc6, 8'hc6, 8'hc6, 8'hc6, 8'hc6);
      e_l[0] = 8'hd4; e_l[1] = 8'hbf; e_l[2] = 8'h5d; e_l[3] = 8'h30;
      for (int r = 0; r < 4; r++) addv(1'b1, 2'(r), 8'h04, 8'h66, 8'h81, 8'he5, e_l[r]);
      e_l[0] = 8'hdb; e_l[1] = 8'h13; e_l[2] = 8'h53; e_l[3] = 8'h45;
      for (int r = 0; r < 4; r++) addv(1'b1, 2'(r), 8'h8e, 8'h4d, 8'ha1, 8'hbc, e_l[r]);

      // Reset state
      step("reset0", 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      step("reset1", 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

      // Known-answer table, back to back
      foreach (vecs[i])
         step($sformatf("vec%0d", i), 1'b0, 1'b1, vecs[i].inv, vecs[i].row,
              vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].a3, vecs[i].exp);

      // Hold: result 04 must survive in_valid=0 with changing inputs
      step("hold_load", 1'b0, 1'b1, 1'b0, 2'd0, 8'hd4, 8'hbf, 8'h5d, 8'h30, 8'h04);
      for (int i = 0; i < 3; i++)
         step("hold", 1'b0, 1'b0, 1'(i), 2'(i + 1), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom), 8'h00);
      n_tests++;
      if (col_out !== 8'h04) begin
         n_fail++;
         $display("FAIL hold_value: got %02h expected 04", col_out);
      end

      // Reset overrides in_valid mid-stream, then normal operation resumes
      step("rst_mid_pre", 1'b0, 1'b1, 1'b0, 2'd1, 8'hd4, 8'hbf, 8'h5d, 8'h30, 8'h66);
      step("rst_mid", 1'b1, 1'b1, 1'b0, 2'd3, 8'hdb, 8'h13, 8'h53, 8'h45, 8'hbc);
      step("rst_rel", 1'b0, 1'b1, 1'b0, 2'd3, 8'hdb, 8'h13, 8'h53, 8'h45, 8'hbc);

      // Random vectors, with occasional idle cycles
      for (int i = 0; i < 10000; i++) begin
         logic       iv, v;
         logic [1:0] r;
         logic [7:0] a0, a1, a2, a3;
         iv = 1'($urandom); r = 2'($urandom);
         v  = ($urandom_range(0, 7) != 0);
         a0 = 8'($urandom); a1 = 8'($urandom); a2 = 8'($urandom); a3 = 8'($urandom);
         step("rand", 1'b0, v, iv, r, a0, a1, a2, a3, model(iv, r, a0, a1, a2, a3));
      end

      // Round trip: forward then inverse must reproduce the column
      for (int t = 0; t < 16; t++) begin
         for (int k = 0; k < 4; k++) c[k] = 8'($urandom);
         for (int r = 0; r < 4; r++) begin
            fw[r] = model(1'b0, 2'(r), c[0], c[1], c[2], c[3]);
            step("rt_fwd", 1'b0, 1'b1, 1'b0, 2'(r), c[0], c[1], c[2], c[3], fw[r]);
         end
         for (int r = 0; r < 4; r++) begin
            exp_f[r] = c[r];
            step("rt_inv", 1'b0, 1'b1, 1'b1, 2'(r), fw[0], fw[1], fw[2], fw[3], exp_f[r]);
         end
      end

      step("idle_end", 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
